hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Param BRANCH_PENALTY, default 2, number of consecutive flush cycles per taken branch including the branch_taken cycle; legal range 1..15.
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 id_rn, id_rm, id_rs  in  4 each  ID-stage source register numbers; id_uses_rn, id_uses_rm, id_uses_rs  in  1 each  source-valid qualifiers.
REQ-005 ex_rd  in  4, ex_reg_write  in  1, ex_is_load  in  1  destination, write-enable and load flag of the EX-stage instruction.
REQ-006 ex_rn, ex_rm, ex_rs  in  4 each  EX-stage source register numbers used for forwarding.
REQ-007 mem_rd  in  4, mem_reg_write  in  1, mem_is_load  in  1  MEM-stage destination, write-enable and load flag.
REQ-008 wb_rd  in  4, wb_reg_write  in  1  WB-stage destination and write-enable.
REQ-009 branch_taken  in  1  taken-branch resolution pulse from EX.
REQ-010 pc_enable, if_id_enable, if_id_flush  out  1 each  fetch and IF/ID pipeline controls.
REQ-011 cu_mux_select  out  1  drives control-mux select; 0 injects a NOP (all control signals cleared) into ID/EX.
REQ-012 fwd_a_sel, fwd_b_sel, fwd_c_sel  out  2 each  operand source for ex_rn, ex_rm, ex_rs: 00 register file, 01 MEM result, 10 WB result; 11 never driven.
REQ-013 in_flush  out  1  high when FSM is in FLUSH.
REQ-014 stall_cycles, flush_cycles  out  16 each  saturating performance counters.

Function
REQ-015 FSM states RUN and FLUSH, plus a 4-bit down-counter flush_left; all outputs except counters and in_flush are combinational from state and inputs.
REQ-016 load_use = ex_is_load & ex_reg_write & ((id_uses_rn & id_rn==ex_rd) | (id_uses_rm & id_rm==ex_rd) | (id_uses_rs & id_rs==ex_rd)).
REQ-017 Action priority per cycle: reset > branch_taken > FLUSH state > load_use > normal.
REQ-018 Normal: pc_enable=1, if_id_enable=1, if_id_flush=0, cu_mux_select=1.
REQ-019 Stall (load_use in RUN, no branch_taken): pc_enable=0, if_id_enable=0, if_id_flush=0, cu_mux_select=0; exactly one cycle per hazard instance, no state change.
REQ-020 Flush (branch_taken, or state FLUSH): pc_enable=1, if_id_enable=1, if_id_flush=1, cu_mux_select=0; load_use ignored.
REQ-021 branch_taken in any state: next flush_left=BRANCH_PENALTY-1; next state FLUSH if that value is nonzero, else RUN (restart on taken branch during FLUSH).
REQ-022 FLUSH without branch_taken: flush_left decrements; when flush_left==1, next state RUN.
REQ-023 Forwarding per operand: 01 if mem_reg_write & !mem_is_load & mem_rd==src; else 10 if wb_reg_write & wb_rd==src; else 00.
REQ-024 Register 15 (PC) never forwarded: src==4'hF forces 00.
REQ-025 stall_cycles increments on each clock edge where Stall applied; flush_cycles increments on each edge where Flush applied; both hold at 16'hFFFF.
REQ-026 in_flush = (state==FLUSH).

Reset
REQ-027 While reset=1: pc_enable=0, if_id_enable=0, if_id_flush=1, cu_mux_select=0, all fwd sel=00.
REQ-028 At a reset edge: state=RUN, flush_left=0, stall_cycles=0, flush_cycles=0, in_flush=0; reset mid-FLUSH aborts the flush, RUN on the first cycle after release.

Verification
REQ-029 Reset 2 cycles -> outputs per REQ-027, counters 0; release -> 1,1,0,1 for pc_enable/if_id_enable/if_id_flush/cu_mux_select.
REQ-030 ex_is_load=1, ex_reg_write=1, ex_rd=3, id_rn=3, id_uses_rn=1 -> same cycle pc_enable=0, if_id_enable=0, cu_mux_select=0; stall_cycles=1 after edge; id_uses_rn=0 -> no stall.
REQ-031 ex_rn=5, mem_rd=5, mem_reg_write=1, wb_rd=5, wb_reg_write=1 -> fwd_a_sel=01; mem_is_load=1 -> 10; ex_rn=15 -> 00.
REQ-032 BRANCH_PENALTY=2, branch_taken pulse cycle N, load_use held high -> Flush outputs cycles N and N+1, in_flush=1 only in N+1, Stall in N+2, flush_cycles=2.
REQ-033 branch_taken again in FLUSH cycle N+1 -> flush extends through N+2; reset asserted in N+1 -> RUN, counters 0 after release.
REQ-034 Load-use held for 70000 cycles -> stall_cycles saturates at 16'hFFFF, no wrap.

Source files
------------

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stall detection, taken-branch flush
// sequencing, operand forwarding selection, and stall/flush counters.
module hazard_unit #(
  parameter int unsigned BRANCH_PENALTY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  id_rn,
  input  logic [3:0]  id_rm,
  input  logic [3:0]  id_rs,
  input  logic        id_uses_rn,
  input  logic        id_uses_rm,
  input  logic        id_uses_rs,
  input  logic [3:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        ex_is_load,
  input  logic [3:0]  ex_rn,
  input  logic [3:0]  ex_rm,
  input  logic [3:0]  ex_rs,
  input  logic [3:0]  mem_rd,
  input  logic        mem_reg_write,
  input  logic        mem_is_load,
  input  logic [3:0]  wb_rd,
  input  logic        wb_reg_write,
  input  logic        branch_taken,
  output logic        pc_enable,
  output logic        if_id_enable,
  output logic        if_id_flush,
  output logic        cu_mux_select,
  output logic [1:0]  fwd_a_sel,
  output logic [1:0]  fwd_b_sel,
  output logic [1:0]  fwd_c_sel,
  output logic        in_flush,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_cycles
);

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [3:0] PENALTY_LEFT = 4'(BRANCH_PENALTY - 1);

  state_t     state, state_nxt;
  logic [3:0] flush_left, flush_left_nxt;
  logic       load_use;
  logic       do_flush;
  logic       do_stall;

  // Operand source: MEM result unless it is a load (data not ready), then WB;
  // the PC register is never forwarded.
  function automatic logic [1:0] fwd_sel_for(input logic [3:0] src);
    logic [1:0] sel;
    sel = 2'b00;
    if (src != 4'hF) begin
      if (mem_reg_write && !mem_is_load && (mem_rd == src))
        sel = 2'b01;
      else if (wb_reg_write && (wb_rd == src))
        sel = 2'b10;
    end
    return sel;
  endfunction

  // Load-use detection and per-cycle action selection (branch beats FLUSH beats stall).
  always_comb begin
    load_use = ex_is_load && ex_reg_write &&
               ((id_uses_rn && (id_rn == ex_rd)) ||
                (id_uses_rm && (id_rm == ex_rd)) ||
                (id_uses_rs && (id_rs == ex_rd)));
    do_flush = !reset && (branch_taken || (state == FLUSH));
    do_stall = !reset && !branch_taken && (state == RUN) && load_use;
  end

  // Next-state: a taken branch (re)starts the flush window in any state.
  always_comb begin
    state_nxt      = state;
    flush_left_nxt = flush_left;
    if (branch_taken) begin
      flush_left_nxt = PENALTY_LEFT;
      state_nxt      = (PENALTY_LEFT != 4'd0) ? FLUSH : RUN;
    end else if (state == FLUSH) begin
      flush_left_nxt = flush_left - 4'd1;
      if (flush_left == 4'd1)
        state_nxt = RUN;
    end
  end

  // Pipeline control and forwarding outputs.
  always_comb begin
    pc_enable     = 1'b1;
    if_id_enable  = 1'b1;
    if_id_flush   = 1'b0;
    cu_mux_select = 1'b1;
    fwd_a_sel     = fwd_sel_for(ex_rn);
    fwd_b_sel     = fwd_sel_for(ex_rm);
    fwd_c_sel     = fwd_sel_for(ex_rs);
    if (reset) begin
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
      if_id_flush   = 1'b1;
      cu_mux_select = 1'b0;
      fwd_a_sel     = 2'b00;
      fwd_b_sel     = 2'b00;
      fwd_c_sel     = 2'b00;
    end else if (do_flush) begin
      if_id_flush   = 1'b1;
      cu_mux_select = 1'b0;
    end else if (do_stall) begin
      pc_enable     = 1'b0;
      if_id_enable  = 1'b0;
      cu_mux_select = 1'b0;
    end
  end

  // State register and saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      flush_left   <= '0;
      stall_cycles <= '0;
      flush_cycles <= '0;
    end else begin
      state      <= state_nxt;
      flush_left <= flush_left_nxt;
      if (do_stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 16'd1;
      if (do_flush && (flush_cycles != '1))
        flush_cycles <= flush_cycles + 16'd1;
    end
  end

  assign in_flush = (state == FLUSH);

endmodule

// File: tb/tb_hazard_unit.sv
// Directed self-checking bench for hazard_unit (BRANCH_PENALTY = 2).
module tb_hazard_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  id_rn, id_rm, id_rs;
  logic        id_uses_rn, id_uses_rm, id_uses_rs;
  logic [3:0]  ex_rd;
  logic        ex_reg_write, ex_is_load;
  logic [3:0]  ex_rn, ex_rm, ex_rs;
  logic [3:0]  mem_rd;
  logic        mem_reg_write, mem_is_load;
  logic [3:0]  wb_rd;
  logic        wb_reg_write;
  logic        branch_taken;
  logic        pc_enable, if_id_enable, if_id_flush, cu_mux_select;
  logic [1:0]  fwd_a_sel, fwd_b_sel, fwd_c_sel;
  logic        in_flush;
  logic [15:0] stall_cycles, flush_cycles;

  int checks = 0;
  int errors = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  localparam logic [3:0] CTL_NORMAL = 4'b1101;
  localparam logic [3:0] CTL_STALL  = 4'b0000;
  localparam logic [3:0] CTL_FLUSH  = 4'b1110;
  localparam logic [3:0] CTL_RESET  = 4'b0010;

  wire [3:0] ctl = {pc_enable, if_id_enable, if_id_flush, cu_mux_select};

  hazard_unit #(.BRANCH_PENALTY(2)) dut (
    .clk(clk), .reset(reset),
    .id_rn(id_rn), .id_rm(id_rm), .id_rs(id_rs),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .id_uses_rs(id_uses_rs),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
    .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_rs(ex_rs),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .branch_taken(branch_taken),
    .pc_enable(pc_enable), .if_id_enable(if_id_enable), .if_id_flush(if_id_flush),
    .cu_mux_select(cu_mux_select),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .fwd_c_sel(fwd_c_sel),
    .in_flush(in_flush), .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {id_rn, id_rm, id_rs} = '0;
    {id_uses_rn, id_uses_rm, id_uses_rs} = '0;
    ex_rd = 4'd0; ex_reg_write = 1'b0; ex_is_load = 1'b0;
    ex_rn = 4'd0; ex_rm = 4'd0; ex_rs = 4'd0;
    mem_rd = 4'd0; mem_reg_write = 1'b0; mem_is_load = 1'b0;
    wb_rd = 4'd0; wb_reg_write = 1'b0;
    branch_taken = 1'b0;
  endtask

  task automatic set_load_use();
    ex_is_load = 1'b1; ex_reg_write = 1'b1; ex_rd = 4'd3;
    id_rn = 4'd3; id_uses_rn = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    ex_rn = 4'd5; mem_rd = 4'd5; mem_reg_write = 1'b1;
    step();
    checks++;
    if (ctl !== CTL_RESET) begin
      errors++; $display("FAIL reset_ctl got %b exp %b", ctl, CTL_RESET);
    end
    checks++;
    if ({fwd_a_sel, fwd_b_sel, fwd_c_sel} !== 6'b0) begin
      errors++; $display("FAIL reset_fwd got %b exp 000000", {fwd_a_sel, fwd_b_sel, fwd_c_sel});
    end
    step();
    checks++;
    if ({stall_cycles, flush_cycles, in_flush} !== 33'b0) begin
      errors++; $display("FAIL reset_state got %h/%h/%b exp 0/0/0", stall_cycles, flush_cycles, in_flush);
    end
    reset = 1'b0;
    clear_inputs();
    #1;
    checks++;
    if (ctl !== CTL_NORMAL) begin
      errors++; $display("FAIL release_ctl got %b exp %b", ctl, CTL_NORMAL);
    end
    exp_stall = 0; exp_flush = 0;
  endtask

  task automatic test_load_use();
    set_load_use();
    #1;
    checks++;
    if (ctl !== CTL_STALL) begin
      errors++; $display("FAIL lu_stall_ctl got %b exp %b", ctl, CTL_STALL);
    end
    step(); exp_stall++;
    checks++;
    if (stall_cycles !== 16'(exp_stall)) begin
      errors++; $display("FAIL lu_stall_count got %0d exp %0d", stall_cycles, exp_stall);
    end
    id_uses_rn = 1'b0;
    #1;
    checks++;
    if (ctl !== CTL_NORMAL) begin
      errors++; $display("FAIL lu_unqualified got %b exp %b", ctl, CTL_NORMAL);
    end
    id_rs = 4'd3; id_uses_rs = 1'b1;
    #1;
    checks++;
    if (ctl !== CTL_STALL) begin
      errors++; $display("FAIL lu_rs_stall got %b exp %b", ctl, CTL_STALL);
    end
    ex_reg_write = 1'b0;
    #1;
    checks++;
    if (ctl !== CTL_NORMAL) begin
      errors++; $display("FAIL lu_no_write got %b exp %b", ctl, CTL_NORMAL);
    end
    step();
    checks++;
    if (stall_cycles !== 16'(exp_stall)) begin
      errors++; $display("FAIL lu_count_hold got %0d exp %0d", stall_cycles, exp_stall);
    end
    clear_inputs();
  endtask

  task automatic test_forwarding();
    ex_rn = 4'd5; mem_rd = 4'd5; mem_reg_write = 1'b1; wb_rd = 4'd5; wb_reg_write = 1'b1;
    ex_rm = 4'd7; ex_rs = 4'd2;
    #1;
    checks++;
    if (fwd_a_sel !== 2'b01) begin
      errors++; $display("FAIL fwd_mem got %b exp 01", fwd_a_sel);
    end
    checks++;
    if ({fwd_b_sel, fwd_c_sel} !== 4'b0000) begin
      errors++; $display("FAIL fwd_none got %b exp 0000", {fwd_b_sel, fwd_c_sel});
    end
    mem_is_load = 1'b1;
    #1;
    checks++;
    if (fwd_a_sel !== 2'b10) begin
      errors++; $display("FAIL fwd_mem_load got %b exp 10", fwd_a_sel);
    end
    mem_is_load = 1'b0; ex_rn = 4'hF; mem_rd = 4'hF; wb_rd = 4'hF;
    #1;
    checks++;
    if (fwd_a_sel !== 2'b00) begin
      errors++; $display("FAIL fwd_pc got %b exp 00", fwd_a_sel);
    end
    wb_rd = 4'd7; ex_rs = 4'd7; mem_rd = 4'd2;
    #1;
    checks++;
    if ({fwd_b_sel, fwd_c_sel} !== 4'b1010) begin
      errors++; $display("FAIL fwd_wb_bc got %b exp 1010", {fwd_b_sel, fwd_c_sel});
    end
    clear_inputs();
  endtask

  task automatic test_branch_flush();
    set_load_use();
    branch_taken = 1'b1;
    #1;
    checks++;
    if ({ctl, in_flush} !== {CTL_FLUSH, 1'b0}) begin
      errors++; $display("FAIL br_cycle_n got %b exp %b", {ctl, in_flush}, {CTL_FLUSH, 1'b0});
    end
    step(); exp_flush++;
    branch_taken = 1'b0;
    #1;
    checks++;
    if ({ctl, in_flush} !== {CTL_FLUSH, 1'b1}) begin
      errors++; $display("FAIL br_cycle_n1 got %b exp %b", {ctl, in_flush}, {CTL_FLUSH, 1'b1});
    end
    step(); exp_flush++;
    checks++;
    if ({ctl, in_flush} !== {CTL_STALL, 1'b0}) begin
      errors++; $display("FAIL br_cycle_n2 got %b exp %b", {ctl, in_flush}, {CTL_STALL, 1'b0});
    end
    step(); exp_stall++;
    checks++;
    if (flush_cycles !== 16'(exp_flush) || stall_cycles !== 16'(exp_stall)) begin
      errors++; $display("FAIL br_counts got %0d/%0d exp %0d/%0d",
                         flush_cycles, stall_cycles, exp_flush, exp_stall);
    end
    clear_inputs();
  endtask

  task automatic test_branch_restart();
    branch_taken = 1'b1;
    step(); exp_flush++;
    #1;
    checks++;
    if ({ctl, in_flush} !== {CTL_FLUSH, 1'b1}) begin
      errors++; $display("FAIL rb_n1 got %b exp %b", {ctl, in_flush}, {CTL_FLUSH, 1'b1});
    end
    step(); exp_flush++;
    branch_taken = 1'b0;
    #1;
    checks++;
    if ({ctl, in_flush} !== {CTL_FLUSH, 1'b1}) begin
      errors++; $display("FAIL rb_n2 got %b exp %b", {ctl, in_flush}, {CTL_FLUSH, 1'b1});
    end
    step(); exp_flush++;
    checks++;
    if ({ctl, in_flush} !== {CTL_NORMAL, 1'b0}) begin
      errors++; $display("FAIL rb_n3 got %b exp %b", {ctl, in_flush}, {CTL_NORMAL, 1'b0});
    end
    checks++;
    if (flush_cycles !== 16'(exp_flush)) begin
      errors++; $display("FAIL rb_count got %0d exp %0d", flush_cycles, exp_flush);
    end
  endtask

  task automatic test_reset_mid_flush();
    branch_taken = 1'b1;
    step();
    branch_taken = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (ctl !== CTL_RESET) begin
      errors++; $display("FAIL rmf_ctl got %b exp %b", ctl, CTL_RESET);
    end
    step();
    reset = 1'b0;
    #1;
    exp_stall = 0; exp_flush = 0;
    checks++;
    if ({ctl, in_flush} !== {CTL_NORMAL, 1'b0}) begin
      errors++; $display("FAIL rmf_release got %b exp %b", {ctl, in_flush}, {CTL_NORMAL, 1'b0});
    end
    checks++;
    if ({stall_cycles, flush_cycles} !== 32'b0) begin
      errors++; $display("FAIL rmf_counts got %h/%h exp 0/0", stall_cycles, flush_cycles);
    end
    step();
    checks++;
    if (in_flush !== 1'b0) begin
      errors++; $display("FAIL rmf_stays_run got %b exp 0", in_flush);
    end
  endtask

  task automatic test_saturation();
    set_load_use();
    repeat (65534) step();
    checks++;
    if (stall_cycles !== 16'hFFFE) begin
      errors++; $display("FAIL sat_pre got %h exp FFFE", stall_cycles);
    end
    step();
    checks++;
    if (stall_cycles !== 16'hFFFF) begin
      errors++; $display("FAIL sat_reach got %h exp FFFF", stall_cycles);
    end
    repeat (4465) step();
    checks++;
    if (stall_cycles !== 16'hFFFF || ctl !== CTL_STALL) begin
      errors++; $display("FAIL sat_hold got %h/%b exp FFFF/%b", stall_cycles, ctl, CTL_STALL);
    end
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    #1;
    test_reset();
    test_load_use();
    test_forwarding();
    test_branch_flush();
    test_branch_restart();
    test_reset_mid_flush();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
